usb_host_ctrl_xfr: RTL and testbench

Host-side control-transfer initiator for endpoint 0. It is the counterpart to the device control endpoint: it drives SETUP, optional DATA IN/OUT, and STATUS stages through a host transaction engine (token + data + handshake). It tracks DATA0/DATA1 toggles and wLength, and reports the outcome. It is used by the loopback bench and by host-mode bring-up.

---
 rtl/usb_host_ctrl_xfr.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_usb_host_ctrl_xfr.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_host_ctrl_xfr.sv
// ---------------------------------------------------------------------------
// usb_host_ctrl_xfr
// Host-side control-transfer initiator for endpoint 0. Sequences the SETUP,
// optional DATA IN/OUT and STATUS stages through a token/data/handshake
// transaction engine, tracks DATA0/DATA1 toggles and wLength, and reports the
// transfer outcome.
//
// Optional build macro: USB_HOST_CTRL_NAK_TIMEOUT_EN
//   defined   : more than NAK_LIMIT consecutive NAKs end the transfer (ERROR)
//   undefined : NAKs are retried indefinitely
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        start request (accepted only in IDLE)
//   cmd_setup, cmd_dev_addr    8 setup bytes (byte0 in [7:0]) and device address
//   txn_req/txn_pid/txn_addr   transaction request to the engine
//   txn_data_pid, txn_len      DATA0/1 selector and SETUP/OUT payload length
//   tx_data_get, tx_data       engine pulls SETUP/OUT payload bytes
//   rx_data_put, rx_data       engine pushes IN payload bytes
//   txn_done, txn_result       transaction outcome (ACK/NAK/STALL/ERROR)
//   out_data_get, out_data     OUT-stage byte pull from the user
//   rsp_valid, rsp_data        IN-stage byte delivered to the user
//   xfr_done, xfr_status       completion pulse and OK/STALL/ERROR status
//   xfr_bytes                  data-stage bytes transferred
// ---------------------------------------------------------------------------
module usb_host_ctrl_xfr #(
  parameter int MAX_PKT     = 32,
  parameter int NAK_LIMIT   = 255,
  parameter int ERR_RETRIES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_setup,
  input  logic [6:0]  cmd_dev_addr,
  output logic        txn_req,
  output logic [3:0]  txn_pid,
  output logic [6:0]  txn_addr,
  output logic        txn_data_pid,
  output logic [6:0]  txn_len,
  input  logic        tx_data_get,
  output logic [7:0]  tx_data,
  input  logic        rx_data_put,
  input  logic [7:0]  rx_data,
  input  logic        txn_done,
  input  logic [1:0]  txn_result,
  output logic        out_data_get,
  input  logic [7:0]  out_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        xfr_done,
  output logic [1:0]  xfr_status,
  output logic [15:0] xfr_bytes
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SETUP      = 3'd1;
  localparam logic [2:0] ST_DATA_IN    = 3'd2;
  localparam logic [2:0] ST_DATA_OUT   = 3'd3;
  localparam logic [2:0] ST_STATUS_IN  = 3'd4;
  localparam logic [2:0] ST_STATUS_OUT = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_OUT   = 4'b0001;

  localparam logic [1:0] RES_ACK   = 2'd0;
  localparam logic [1:0] RES_NAK   = 2'd1;
  localparam logic [1:0] RES_STALL = 2'd2;

  localparam logic [1:0] XS_OK    = 2'd0;
  localparam logic [1:0] XS_STALL = 2'd1;
  localparam logic [1:0] XS_ERROR = 2'd2;

  localparam logic [6:0]  MAX_PKT_7   = 7'(MAX_PKT);
  localparam logic [7:0]  MAX_PKT_8   = 8'(MAX_PKT);
  localparam logic [15:0] MAX_PKT_16  = 16'(MAX_PKT);
  localparam logic [7:0]  ERR_LIMIT_8 = 8'(ERR_RETRIES);

  logic [2:0]  state_r;
  logic [63:0] setup_r;
  logic [6:0]  addr_r;
  logic        toggle_r;
  logic [2:0]  idx_r;
  logic [15:0] xfr_bytes_r;
  logic [15:0] pkt_start_r;   // xfr_bytes at packet start, restored on a failed IN
  logic [7:0]  pkt_cnt_r;     // raw bytes seen in the current IN packet
  logic [7:0]  err_cnt_r;
  logic        req_r;
  logic        rsp_valid_r;
  logic [7:0]  rsp_data_r;
  logic [1:0]  status_r;

  logic [15:0] wlen_s;
  logic [15:0] rem_s;
  logic [6:0]  out_len_s;
  logic        in_put_s;
  logic [15:0] in_bytes_nxt_s;
  logic [15:0] out_bytes_nxt_s;
  logic [7:0]  pkt_cnt_nxt_s;
  logic [7:0]  err_nxt_s;

`ifdef USB_HOST_CTRL_NAK_TIMEOUT_EN
  localparam logic [8:0] NAK_LIMIT_9 = 9'(NAK_LIMIT);
  logic [7:0] nak_cnt_r;
  logic [8:0] nak_nxt_s;
  assign nak_nxt_s = {1'b0, nak_cnt_r} + 9'd1;
`else
  logic [8:0] nak_limit_unused_s;
  assign nak_limit_unused_s = 9'(NAK_LIMIT);
`endif

  assign wlen_s          = setup_r[63:48];
  assign rem_s           = wlen_s - xfr_bytes_r;
  assign out_len_s       = (rem_s > MAX_PKT_16) ? MAX_PKT_7 : rem_s[6:0];
  // Bytes past wLength are dropped: they are neither forwarded nor counted.
  assign in_put_s        = req_r && (state_r == ST_DATA_IN) && rx_data_put && (xfr_bytes_r < wlen_s);
  assign in_bytes_nxt_s  = xfr_bytes_r + {15'd0, in_put_s};
  assign out_bytes_nxt_s = xfr_bytes_r + {9'd0, out_len_s};
  assign err_nxt_s       = err_cnt_r + 8'd1;

  assign cmd_ready  = (state_r == ST_IDLE);
  assign txn_req    = req_r;
  assign txn_addr   = addr_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign xfr_done   = (state_r == ST_DONE);
  assign xfr_status = status_r;
  assign xfr_bytes  = xfr_bytes_r;

  // Saturating raw byte count of the IN packet, used for short-packet detection.
  always_comb begin
    pkt_cnt_nxt_s = pkt_cnt_r;
    if (rx_data_put && (pkt_cnt_r != 8'hFF)) begin
      pkt_cnt_nxt_s = pkt_cnt_r + 8'd1;
    end else begin
      pkt_cnt_nxt_s = pkt_cnt_r;
    end
  end

  // Per-stage transaction descriptor and payload muxing toward the engine.
  always_comb begin
    txn_pid      = 4'd0;
    txn_data_pid = 1'b0;
    txn_len      = 7'd0;
    tx_data      = 8'd0;
    out_data_get = 1'b0;
    case (state_r)
      ST_SETUP: begin
        txn_pid = PID_SETUP;
        txn_len = 7'd8;
        tx_data = setup_r[{idx_r, 3'b000} +: 8];
      end
      ST_DATA_IN: begin
        txn_pid      = PID_IN;
        txn_data_pid = toggle_r;
      end
      ST_DATA_OUT: begin
        txn_pid      = PID_OUT;
        txn_data_pid = toggle_r;
        txn_len      = out_len_s;
        tx_data      = out_data;
        out_data_get = tx_data_get;
      end
      ST_STATUS_IN: begin
        txn_pid      = PID_IN;
        txn_data_pid = 1'b1;
      end
      ST_STATUS_OUT: begin
        txn_pid      = PID_OUT;
        txn_data_pid = 1'b1;
      end
      default: begin
        txn_pid = 4'd0;
      end
    endcase
  end

  // Transfer sequencer: stage FSM, request handshake, counters and retries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      setup_r     <= 64'd0;
      addr_r      <= 7'd0;
      toggle_r    <= 1'b0;
      idx_r       <= 3'd0;
      xfr_bytes_r <= 16'd0;
      pkt_start_r <= 16'd0;
      pkt_cnt_r   <= 8'd0;
      err_cnt_r   <= 8'd0;
      req_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'd0;
      status_r    <= XS_OK;
`ifdef USB_HOST_CTRL_NAK_TIMEOUT_EN
      nak_cnt_r   <= 8'd0;
`endif
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            setup_r     <= cmd_setup;
            addr_r      <= cmd_dev_addr;
            xfr_bytes_r <= 16'd0;
            err_cnt_r   <= 8'd0;
            toggle_r    <= 1'b0;
            status_r    <= XS_OK;
`ifdef USB_HOST_CTRL_NAK_TIMEOUT_EN
            nak_cnt_r   <= 8'd0;
`endif
            state_r     <= ST_SETUP;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        ST_SETUP, ST_DATA_IN, ST_DATA_OUT, ST_STATUS_IN, ST_STATUS_OUT: begin
          // req is low for at least one cycle between transactions.
          if (!req_r) begin
            req_r       <= 1'b1;
            pkt_start_r <= xfr_bytes_r;
            pkt_cnt_r   <= 8'd0;
            idx_r       <= 3'd0;
          end else begin
            if ((state_r == ST_SETUP) && tx_data_get) begin
              idx_r <= idx_r + 3'd1;
            end
            if (state_r == ST_DATA_IN) begin
              pkt_cnt_r <= pkt_cnt_nxt_s;
            end
            if (in_put_s) begin
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= rx_data;
              xfr_bytes_r <= in_bytes_nxt_s;
            end
            if (txn_done) begin
              req_r <= 1'b0;
              idx_r <= 3'd0;
              case (txn_result)
                RES_ACK: begin
                  err_cnt_r <= 8'd0;
`ifdef USB_HOST_CTRL_NAK_TIMEOUT_EN
                  nak_cnt_r <= 8'd0;
`endif
                  case (state_r)
                    ST_SETUP: begin
                      toggle_r <= 1'b1;
                      if (wlen_s == 16'd0) begin
                        state_r <= ST_STATUS_IN;
                      end else if (setup_r[7]) begin
                        state_r <= ST_DATA_IN;
                      end else begin
                        state_r <= ST_DATA_OUT;
                      end
                    end
                    ST_DATA_IN: begin
                      toggle_r <= ~toggle_r;
                      if ((pkt_cnt_nxt_s < MAX_PKT_8) || (in_bytes_nxt_s == wlen_s)) begin
                        state_r <= ST_STATUS_OUT;
                      end
                    end
                    ST_DATA_OUT: begin
                      toggle_r    <= ~toggle_r;
                      xfr_bytes_r <= out_bytes_nxt_s;
                      if (out_bytes_nxt_s == wlen_s) begin
                        state_r <= ST_STATUS_IN;
                      end
                    end
                    default: begin
                      state_r <= ST_DONE;
                    end
                  endcase
                end
                RES_NAK: begin
                  // Same toggle on retry; an IN packet's count is rolled back.
                  if (state_r == ST_DATA_IN) begin
                    xfr_bytes_r <= pkt_start_r;
                  end
`ifdef USB_HOST_CTRL_NAK_TIMEOUT_EN
                  if (nak_nxt_s > NAK_LIMIT_9) begin
                    status_r <= XS_ERROR;
                    state_r  <= ST_DONE;
                  end else begin
                    nak_cnt_r <= nak_nxt_s[7:0];
                  end
`endif
                end
                RES_STALL: begin
                  status_r <= XS_STALL;
                  state_r  <= ST_DONE;
                end
                default: begin
                  if (state_r == ST_DATA_IN) begin
                    xfr_bytes_r <= pkt_start_r;
                  end
                  if (err_nxt_s >= ERR_LIMIT_8) begin
                    status_r <= XS_ERROR;
                    state_r  <= ST_DONE;
                  end else begin
                    err_cnt_r <= err_nxt_s;
                  end
                end
              endcase
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_host_ctrl_xfr.sv
// Directed testbench for usb_host_ctrl_xfr: the bench plays the transaction
// engine and the user, and checks every stage against hand-derived values.
module tb_usb_host_ctrl_xfr;

  localparam logic [3:0] P_SETUP = 4'b1101;
  localparam logic [3:0] P_IN    = 4'b1001;
  localparam logic [3:0] P_OUT   = 4'b0001;
  localparam logic [1:0] R_ACK   = 2'd0;
  localparam logic [1:0] R_NAK   = 2'd1;
  localparam logic [1:0] R_STALL = 2'd2;
  localparam logic [1:0] R_ERR   = 2'd3;
`ifdef USB_HOST_CTRL_NAK_TIMEOUT_EN
  localparam int NAK_LIM = 4;
`else
  localparam int NAK_LIM = 255;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_setup;
  logic [6:0]  cmd_dev_addr;
  logic        txn_req;
  logic [3:0]  txn_pid;
  logic [6:0]  txn_addr;
  logic        txn_data_pid;
  logic [6:0]  txn_len;
  logic        tx_data_get;
  logic [7:0]  tx_data;
  logic        rx_data_put;
  logic [7:0]  rx_data;
  logic        txn_done;
  logic [1:0]  txn_result;
  logic        out_data_get;
  logic [7:0]  out_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        xfr_done;
  logic [1:0]  xfr_status;
  logic [15:0] xfr_bytes;

  usb_host_ctrl_xfr #(.MAX_PKT(32), .NAK_LIMIT(NAK_LIM), .ERR_RETRIES(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_setup(cmd_setup), .cmd_dev_addr(cmd_dev_addr), .txn_req(txn_req),
    .txn_pid(txn_pid), .txn_addr(txn_addr), .txn_data_pid(txn_data_pid),
    .txn_len(txn_len), .tx_data_get(tx_data_get), .tx_data(tx_data),
    .rx_data_put(rx_data_put), .rx_data(rx_data), .txn_done(txn_done),
    .txn_result(txn_result), .out_data_get(out_data_get), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .xfr_done(xfr_done),
    .xfr_status(xfr_status), .xfr_bytes(xfr_bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] cur_setup;
  logic [6:0]  cur_addr;
  int rx_idx;

  // Free-running event counters; tests compare differences.
  int rsp_cnt = 0;
  int rsp_sum = 0;
  int get_cnt = 0;
  int req_rise = 0;
  int done_cnt = 0;
  logic req_d = 1'b0;
  always @(posedge clk) begin
    if (rsp_valid) begin
      rsp_cnt = rsp_cnt + 1;
      rsp_sum = rsp_sum + int'(rsp_data);
    end
    if (out_data_get) get_cnt = get_cnt + 1;
    if (txn_req && !req_d) req_rise = req_rise + 1;
    if (xfr_done) done_cnt = done_cnt + 1;
    req_d = txn_req;
  end

  function automatic logic [7:0] pat(input int k);
    logic [7:0] b;
    b = k[7:0] * 8'd7 + 8'd3;
    return b;
  endfunction

  function automatic int exp_sum(input int n);
    int s;
    s = 0;
    for (int k = 0; k < n; k++) s = s + int'(pat(k));
    return s;
  endfunction

  task automatic start_cmd(input logic [63:0] s, input logic [6:0] a, input string nm);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready before accept: got %b want 1", nm, cmd_ready);
    end
    cmd_setup = s; cmd_dev_addr = a; cmd_valid = 1'b1;
    cur_setup = s; cur_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s cmd_ready after accept: got %b want 0", nm, cmd_ready);
    end
  endtask

  // Engine model: wait for a request, check it, move payload, report result.
  task automatic do_txn(input logic [3:0] epid, input logic edp, input logic [6:0] elen,
                        input int nin, input logic [1:0] res, input string nm);
    int w;
    logic [7:0] exp_b;
    w = 0;
    while (txn_req !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (txn_req !== 1'b1) begin
      errors++;
      $display("FAIL %s req timeout: txn_req=%b want 1", nm, txn_req);
      return;
    end
    checks++;
    if (txn_pid !== epid) begin
      errors++;
      $display("FAIL %s pid: got %b want %b", nm, txn_pid, epid);
    end
    checks++;
    if (txn_data_pid !== edp) begin
      errors++;
      $display("FAIL %s data_pid: got %b want %b", nm, txn_data_pid, edp);
    end
    checks++;
    if (txn_addr !== cur_addr) begin
      errors++;
      $display("FAIL %s addr: got %h want %h", nm, txn_addr, cur_addr);
    end
    if (epid != P_IN) begin
      checks++;
      if (txn_len !== elen) begin
        errors++;
        $display("FAIL %s len: got %0d want %0d", nm, txn_len, elen);
      end
      for (int i = 0; i < int'(elen); i++) begin
        tx_data_get = 1'b1;
        out_data = 8'hA0 + i[7:0];
        #1;
        exp_b = (epid == P_SETUP) ? cur_setup[i*8 +: 8] : out_data;
        checks++;
        if (tx_data !== exp_b) begin
          errors++;
          $display("FAIL %s tx_data[%0d]: got %h want %h", nm, i, tx_data, exp_b);
        end
        @(negedge clk);
      end
      tx_data_get = 1'b0;
    end else begin
      for (int i = 0; i < nin; i++) begin
        rx_data_put = 1'b1;
        rx_data = pat(rx_idx);
        rx_idx++;
        @(negedge clk);
      end
      rx_data_put = 1'b0;
    end
    txn_done = 1'b1; txn_result = res;
    @(negedge clk);
    txn_done = 1'b0; txn_result = 2'd0;
    checks++;
    if (txn_req !== 1'b0) begin
      errors++;
      $display("FAIL %s req after done: got %b want 0", nm, txn_req);
    end
  endtask

  task automatic wait_done(input logic [1:0] st, input logic [15:0] by, input string nm);
    int w;
    w = 0;
    while (xfr_done !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (xfr_done !== 1'b1) begin
      errors++;
      $display("FAIL %s xfr_done timeout: got %b want 1", nm, xfr_done);
      return;
    end
    checks++;
    if (xfr_status !== st) begin
      errors++;
      $display("FAIL %s status: got %0d want %0d", nm, xfr_status, st);
    end
    checks++;
    if (xfr_bytes !== by) begin
      errors++;
      $display("FAIL %s xfr_bytes: got %0d want %0d", nm, xfr_bytes, by);
    end
    @(negedge clk);
    checks++;
    if (xfr_done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after done: xfr_done=%b cmd_ready=%b want 0/1", nm, xfr_done, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_setup = 64'd0; cmd_dev_addr = 7'd0;
    tx_data_get = 1'b0; rx_data_put = 1'b0; rx_data = 8'd0; txn_done = 1'b0;
    txn_result = 2'd0; out_data = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({txn_req, txn_pid, txn_addr, txn_data_pid, txn_len, tx_data, out_data_get,
         rsp_valid, rsp_data, xfr_done, xfr_status, xfr_bytes} !== 63'd0) begin
      errors++;
      $display("FAIL reset outputs: req=%b pid=%b addr=%h len=%0d done=%b st=%0d bytes=%0d want all 0",
               txn_req, txn_pid, txn_addr, txn_len, xfr_done, xfr_status, xfr_bytes);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_get_descriptor();
    int c0, s0;
    c0 = rsp_cnt; s0 = rsp_sum; rx_idx = 0;
    start_cmd(64'h0012_0000_0100_0680, 7'h05, "gd");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "gd_setup");
    do_txn(P_IN, 1'b1, 7'd0, 18, R_ACK, "gd_in");
    do_txn(P_OUT, 1'b1, 7'd0, 0, R_ACK, "gd_status");
    wait_done(2'd0, 16'd18, "gd");
    checks++;
    if (rsp_cnt - c0 != 18 || rsp_sum - s0 != exp_sum(18)) begin
      errors++;
      $display("FAIL gd rsp: count %0d sum %0d want 18 sum %0d", rsp_cnt - c0, rsp_sum - s0, exp_sum(18));
    end
  endtask

  task automatic test_config_descriptor();
    int c0, s0;
    c0 = rsp_cnt; s0 = rsp_sum; rx_idx = 0;
    start_cmd(64'h0043_0000_0200_0680, 7'h05, "cfg");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "cfg_setup");
    do_txn(P_IN, 1'b1, 7'd0, 32, R_ACK, "cfg_in0");
    do_txn(P_IN, 1'b0, 7'd0, 32, R_ACK, "cfg_in1");
    do_txn(P_IN, 1'b1, 7'd0, 3, R_ACK, "cfg_in2");
    do_txn(P_OUT, 1'b1, 7'd0, 0, R_ACK, "cfg_status");
    wait_done(2'd0, 16'd67, "cfg");
    checks++;
    if (rsp_cnt - c0 != 67 || rsp_sum - s0 != exp_sum(67)) begin
      errors++;
      $display("FAIL cfg rsp: count %0d sum %0d want 67 sum %0d", rsp_cnt - c0, rsp_sum - s0, exp_sum(67));
    end
  endtask

  task automatic test_set_address();
    int r0;
    r0 = req_rise;
    start_cmd(64'h0000_0000_0005_0500, 7'h00, "sa");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "sa_setup");
    do_txn(P_IN, 1'b1, 7'd0, 0, R_ACK, "sa_status");
    wait_done(2'd0, 16'd0, "sa");
    checks++;
    if (req_rise - r0 != 2) begin
      errors++;
      $display("FAIL sa txn count: got %0d want 2", req_rise - r0);
    end
  endtask

  task automatic test_line_coding_nak();
    int g0;
    g0 = get_cnt;
    start_cmd(64'h0007_0000_0000_2021, 7'h05, "lc");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "lc_setup");
    do_txn(P_OUT, 1'b1, 7'd7, 0, R_NAK, "lc_out_nak0");
    do_txn(P_OUT, 1'b1, 7'd7, 0, R_NAK, "lc_out_nak1");
    do_txn(P_OUT, 1'b1, 7'd7, 0, R_ACK, "lc_out_ack");
    do_txn(P_IN, 1'b1, 7'd0, 0, R_ACK, "lc_status");
    wait_done(2'd0, 16'd7, "lc");
    checks++;
    if (get_cnt - g0 != 21) begin
      errors++;
      $display("FAIL lc out_data_get: got %0d want 21", get_cnt - g0);
    end
  endtask

  task automatic test_data_out_multi();
    start_cmd(64'h0028_0000_0000_0040, 7'h09, "om");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "om_setup");
    do_txn(P_OUT, 1'b1, 7'd32, 0, R_ACK, "om_out0");
    do_txn(P_OUT, 1'b0, 7'd8, 0, R_ACK, "om_out1");
    do_txn(P_IN, 1'b1, 7'd0, 0, R_ACK, "om_status");
    wait_done(2'd0, 16'd40, "om");
  endtask

  task automatic test_in_drop();
    int c0;
    c0 = rsp_cnt; rx_idx = 0;
    start_cmd(64'h0005_0000_0300_0680, 7'h05, "drop");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "drop_setup");
    do_txn(P_IN, 1'b1, 7'd0, 8, R_ACK, "drop_in");
    do_txn(P_OUT, 1'b1, 7'd0, 0, R_ACK, "drop_status");
    wait_done(2'd0, 16'd5, "drop");
    checks++;
    if (rsp_cnt - c0 != 5) begin
      errors++;
      $display("FAIL drop rsp count: got %0d want 5", rsp_cnt - c0);
    end
  endtask

  task automatic test_in_retry();
    start_cmd(64'h0028_0000_0100_0680, 7'h05, "rt");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "rt_setup");
    rx_idx = 0;
    do_txn(P_IN, 1'b1, 7'd0, 32, R_ERR, "rt_in_err");
    rx_idx = 0;
    do_txn(P_IN, 1'b1, 7'd0, 32, R_ACK, "rt_in_ack");
    do_txn(P_IN, 1'b0, 7'd0, 8, R_ACK, "rt_in_last");
    do_txn(P_OUT, 1'b1, 7'd0, 0, R_ACK, "rt_status");
    wait_done(2'd0, 16'd40, "rt");
  endtask

  task automatic test_stall();
    int r0;
    start_cmd(64'h0012_0000_0100_0680, 7'h05, "st");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "st_setup");
    do_txn(P_IN, 1'b1, 7'd0, 0, R_STALL, "st_in");
    r0 = req_rise;
    wait_done(2'd1, 16'd0, "st");
    repeat (6) @(negedge clk);
    checks++;
    if (req_rise != r0 || xfr_status !== 2'd1) begin
      errors++;
      $display("FAIL st after stall: extra txns %0d status %0d want 0 and 1", req_rise - r0, xfr_status);
    end
  endtask

  task automatic test_error_retries();
    start_cmd(64'h0000_0000_0005_0500, 7'h00, "er");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ERR, "er_setup0");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ERR, "er_setup1");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ERR, "er_setup2");
    wait_done(2'd2, 16'd0, "er");
  endtask

  task automatic test_nak_limit();
    start_cmd(64'h0000_0000_0005_0500, 7'h00, "nk");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "nk_setup");
`ifdef USB_HOST_CTRL_NAK_TIMEOUT_EN
    for (int i = 0; i < 5; i++) do_txn(P_IN, 1'b1, 7'd0, 0, R_NAK, "nk_status_nak");
    wait_done(2'd2, 16'd0, "nk");
`else
    for (int i = 0; i < 300; i++) do_txn(P_IN, 1'b1, 7'd0, 0, R_NAK, "nk_status_nak");
    do_txn(P_IN, 1'b1, 7'd0, 0, R_ACK, "nk_status_ack");
    wait_done(2'd0, 16'd0, "nk");
`endif
  endtask

  task automatic test_back_to_back();
    start_cmd(64'h0000_0000_0007_0500, 7'h11, "bb0");
    cmd_valid = 1'b1; cmd_setup = 64'h00FF_0000_0000_0680;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bb0 cmd_ready busy: got %b want 0", cmd_ready);
    end
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "bb0_setup");
    cmd_valid = 1'b0;
    do_txn(P_IN, 1'b1, 7'd0, 0, R_ACK, "bb0_status");
    wait_done(2'd0, 16'd0, "bb0");
    start_cmd(64'h0000_0000_0008_0500, 7'h12, "bb1");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "bb1_setup");
    do_txn(P_IN, 1'b1, 7'd0, 0, R_ACK, "bb1_status");
    wait_done(2'd0, 16'd0, "bb1");
  endtask

  task automatic test_reset_mid();
    int d0;
    start_cmd(64'h0012_0000_0100_0680, 7'h05, "rm");
    do_txn(P_SETUP, 1'b0, 7'd8, 0, R_ACK, "rm_setup");
    @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || txn_req !== 1'b0) begin
      errors++;
      $display("FAIL rm after reset: cmd_ready=%b txn_req=%b want 1/0", cmd_ready, txn_req);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0 || txn_req !== 1'b0) begin
      errors++;
      $display("FAIL rm no done: done pulses %0d txn_req=%b want 0/0", done_cnt - d0, txn_req);
    end
  endtask

  initial begin
    test_reset();
    test_get_descriptor();
    test_config_descriptor();
    test_set_address();
    test_line_coding_nak();
    test_data_out_multi();
    test_in_drop();
    test_in_retry();
    test_stall();
    test_error_retries();
    test_nak_limit();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
